blur_seq: RTL and testbench
===========================

BLUR_SEQ -- requirements
Module: blur_seq

Interface
REQ-001 Parameter IMG_W, default 64: image width in pixels (must be >= KSIZE).
REQ-002 Parameter IMG_H, default 64: image height in pixels (must be >= KSIZE).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-006 pix_valid  input  1  upstream pixel present.
REQ-007 pix_ready  output  1  pixel accepted this cycle when pix_valid && pix_ready.
REQ-008 shift_en  output  1  shift-register window advance; equals accept, same cycle, combinational.
REQ-009 arit_pixel  input  8  filtered pixel from the arithmetic block (combinational from window).
REQ-010 out_valid  output  1  output FIFO head valid.
REQ-011 out_ready  input  1  output logic consumes head when out_valid && out_ready.
REQ-012 out_pixel  output  8  output FIFO head data.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-015 FSM states IDLE, FILL, RUN, DRAIN, DONE; IDLE->FILL on start; FILL->RUN on accepting pixel (row=KSIZE-1, col=KSIZE-2); RUN->DRAIN on accepting pixel (IMG_H-1, IMG_W-1); DRAIN->DONE when win_valid=0 and FIFO empty; DONE->IDLE unconditionally next cycle.
REQ-016 col counts 0..IMG_W-1 per accept, wraps to 0 and increments row; row counts 0..IMG_H-1; both cleared on start; widths $clog2 of bound.
REQ-017 win_valid (internal register) set in the cycle after accepting pixel (row, col) with row >= KSIZE-1 and col >= KSIZE-1, cleared otherwise; never set in FILL.
REQ-018 When win_valid=1, arit_pixel is written into the output FIFO at that clock edge; at most one write per cycle.
REQ-019 Output FIFO depth 2; simultaneous write and read at occupancy 2 is legal; read at occupancy 0 never occurs.
REQ-020 pix_ready = (state is FILL or RUN) && (occ + win_valid - (out_valid && out_ready)) <= 1; combinational path from out_ready to pix_ready is permitted.
REQ-021 Sustained throughput one pixel per cycle when pix_valid and out_ready held high.
REQ-022 Exactly (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1) pixels emitted per frame, raster order.
REQ-023 start outside IDLE ignored; pix_valid in IDLE/DRAIN/DONE not accepted.
REQ-024 frame_done high only in DONE; busy low in the same cycle that state is IDLE.

Reset
REQ-025 n_rst low forces state IDLE, row=0, col=0, win_valid=0, FIFO empty, out_valid=0, out_pixel=0, pix_ready=0, shift_en=0, busy=0, frame_done=0, immediately and regardless of clk.
REQ-026 Reset mid-frame discards all in-flight data; next frame requires a new start.

Structure
REQ-027 Shared package plazer_pkg holds KSIZE=17, PIX_W=8 and the state enum type.
REQ-028 Output FIFO is sub-module pix_fifo2 (depth 2, width PIX_W, clk/n_rst, wr, rd, occ).

Verification
REQ-029 IMG_W=IMG_H=20, start, pix_valid=1, out_ready=1, ramp data -> exactly 16 outputs, first win_valid 1 cycle after accept 337 (row 16, col 16), frame_done once, 400 consecutive accepts.
REQ-030 Same frame, out_ready low for 10 cycles during RUN -> occupancy reaches 2, pix_ready low, no output lost/duplicated, order preserved.
REQ-031 out_ready toggling 1/0 each cycle -> FIFO simultaneous read+write at occ 2 holds correct data; 16 outputs total.
REQ-032 start pulsed during RUN -> counters unchanged, output count still 16.
REQ-033 n_rst asserted asynchronously mid-RUN (between edges) -> all outputs zero immediately; new start yields clean 16-output frame.
REQ-034 pix_valid gaps (1 in 3 cycles) -> outputs identical to REQ-029 values, frame_done only after last output consumed.

Source files
------------

// File: rtl/blur_seq_pkg.sv
// Shared constants and FSM state type for the blur sequencer slice.
// Kernel size and pixel width are fixed for the whole filter family.
package plazer_pkg;

    localparam int unsigned KSIZE = 17;
    localparam int unsigned PIX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Occupancy the FIFO would reach after this cycle's write and read.
    function automatic logic [2:0] occ_after(input logic [1:0] occ,
                                             input logic       wr,
                                             input logic       rd);
        return 3'(occ) + 3'(wr) - 3'(rd);
    endfunction

endpackage

// File: rtl/blur_seq_if.sv
// Pixel-in / pixel-out stream bundle between the sequencer, the window
// shift register with its arithmetic block, and the downstream consumer.
interface blur_seq_if;
    import plazer_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic             shift_en;
    logic [PIX_W-1:0] arit_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;

    modport slave (
        input  pix_valid,
        input  arit_pixel,
        input  out_ready,
        output pix_ready,
        output shift_en,
        output out_valid,
        output out_pixel
    );

    modport master (
        output pix_valid,
        output arit_pixel,
        output out_ready,
        input  pix_ready,
        input  shift_en,
        input  out_valid,
        input  out_pixel
    );

endinterface

// File: rtl/blur_seq_fifo.sv
// Two-entry output FIFO; the head reads as zero while empty so the
// output port is clean after reset and between frames.
module pix_fifo2
    import plazer_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd,
    output logic [PIX_W-1:0] rd_data,
    output logic [1:0]       occ
);

    logic [PIX_W-1:0] mem_q [2];
    logic [PIX_W-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        // At full occupancy a write lands in the slot being read this cycle.
        if (wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({wr, rd})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_data = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign occ     = occ_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (!n_rst)
        !(rd && occ_q == 2'd0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
        !(wr && !rd && occ_q == 2'd2));

endmodule

// File: rtl/blur_seq.sv
// Raster sequencer for a KSIZE x KSIZE blur: tracks the pixel position,
// flags full windows, and buffers filtered pixels in a two-entry FIFO.
module blur_seq
    import plazer_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic      clk,
    input  logic      n_rst,
    input  logic      start,
    blur_seq_if.slave bus,
    output logic      busy,
    output logic      frame_done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KSIZE - 1);
    localparam logic [COL_W-1:0] COL_FILL = COL_W'(KSIZE - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KSIZE - 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             win_valid_q, win_valid_d;

    logic             in_stream;
    logic             accept;
    logic             fifo_rd;
    logic [1:0]       occ;
    logic             out_valid;
    logic [PIX_W-1:0] out_pixel;
    logic             last_col;
    logic             last_row;

    // Admission counts the write already committed by win_valid_q, so
    // the FIFO can never be asked to hold a third pixel.
    always_comb begin
        in_stream     = (state_q == ST_FILL) || (state_q == ST_RUN);
        fifo_rd       = out_valid && bus.out_ready;
        bus.pix_ready = in_stream && (occ_after(occ, win_valid_q, fifo_rd) <= 3'd1);
        accept        = bus.pix_valid && bus.pix_ready;
        bus.shift_en  = accept;
    end

    always_comb begin
        last_col = (col_q == COL_LAST);
        last_row = (row_q == ROW_LAST);
        row_d    = row_q;
        col_d    = col_q;
        if (state_q == ST_IDLE && start) begin
            row_d = '0;
            col_d = '0;
        end else if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        win_valid_d = accept && (state_q == ST_RUN) &&
                      (row_q >= ROW_WIN) && (col_q >= COL_WIN);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FILL;
            ST_FILL:  if (accept && row_q == ROW_WIN && col_q == COL_FILL) state_d = ST_RUN;
            ST_RUN:   if (accept && last_row && last_col) state_d = ST_DRAIN;
            ST_DRAIN: if (!win_valid_q && occ == 2'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
        end
    end

    pix_fifo2 u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr      (win_valid_q),
        .wr_data (bus.arit_pixel),
        .rd      (fifo_rd),
        .rd_data (out_pixel),
        .occ     (occ)
    );

    assign out_valid     = (occ != 2'd0);
    assign bus.out_valid = out_valid;
    assign bus.out_pixel = out_pixel;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_DONE);

    a_no_window_in_fill: assert property (@(posedge clk) disable iff (!n_rst)
        (state_q == ST_FILL) |-> !win_valid_q);

endmodule

// File: tb/tb_blur_seq.sv
// Directed bench for blur_seq on a 20x20 image: full rate, backpressure,
// ready toggling, stray start, async reset and input gaps.
module tb_blur_seq;
    import plazer_pkg::*;

    localparam logic [7:0] EXP [16] = '{
        8'h0A, 8'h0B, 8'h08, 8'h09, 8'h3E, 8'h3F, 8'h3C, 8'h3D,
        8'h22, 8'h23, 8'h20, 8'h21, 8'hD6, 8'hD7, 8'hD4, 8'hD5
    };

    logic clk;
    logic n_rst;
    logic start;
    logic busy;
    logic frame_done;

    blur_seq_if bus ();

    blur_seq #(
        .IMG_W (20),
        .IMG_H (20)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Arithmetic-block stand-in: output is the last shifted pixel ^ 0x5A,
    // where pixel value is the raster index of the accept (mod 256).
    int         data_cnt;
    logic [7:0] last_pix;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_cnt <= 0;
            last_pix <= 8'h00;
        end else if (start && !busy) begin
            data_cnt <= 0;
        end else if (bus.shift_en) begin
            last_pix <= data_cnt[7:0];
            data_cnt <= data_cnt + 1;
        end
    end
    assign bus.arit_pixel = last_pix ^ 8'h5A;

    // Per-frame observations, sampled on the falling edge.
    int         cyc = 0;
    int         f_acc, f_first_acc, f_last_acc, f_acc337, f_first_ov;
    int         f_last_out, f_fd_cnt, f_fd_cyc, f_stall;
    bit         f_occ2;
    logic [7:0] f_outs [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (n_rst) begin
            if (start && !busy) begin
                f_acc      <= 0;
                f_first_acc <= -1;
                f_last_acc <= -1;
                f_acc337   <= -1;
                f_first_ov <= -1;
                f_last_out <= -1;
                f_fd_cnt   <= 0;
                f_fd_cyc   <= -1;
                f_stall    <= 0;
                f_occ2     <= 1'b0;
                f_outs.delete();
            end else begin
                if (bus.shift_en) begin
                    f_acc <= f_acc + 1;
                    if (f_acc == 0) f_first_acc <= cyc;
                    if (f_acc == 336) f_acc337 <= cyc;
                    f_last_acc <= cyc;
                end
                if (bus.out_valid && f_first_ov < 0) f_first_ov <= cyc;
                if (bus.out_valid && bus.out_ready) begin
                    f_outs.push_back(bus.out_pixel);
                    f_last_out <= cyc;
                end
                if (frame_done) begin
                    f_fd_cnt <= f_fd_cnt + 1;
                    f_fd_cyc <= cyc;
                end
                if (bus.pix_valid && !bus.pix_ready && f_acc > 0 && f_acc < 400)
                    f_stall <= f_stall + 1;
                if (dut.occ == 2'd2) f_occ2 <= 1'b1;
            end
        end
    end

    // mode: 0 full rate, 1 ready low 10 cycles, 2 ready toggling,
    // 3 stray start in RUN, 4 input gaps, 5 stop mid-RUN (no drain)
    task automatic run_frame(input int mode, output bit timed_out);
        timed_out = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        bus.pix_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (mode == 5 && k == 380) begin
                timed_out = 1'b0;
                return;
            end
            bus.pix_valid = (mode == 4) ? (k % 3 != 2) : 1'b1;
            case (mode)
                1:       bus.out_ready = !(k >= 355 && k < 365);
                2:       bus.out_ready = (k % 2 == 0);
                default: bus.out_ready = 1'b1;
            endcase
            start = (mode == 3 && k == 360);
            @(posedge clk); #1;
            if (f_fd_cnt > 0) begin
                start = 1'b0;
                bus.pix_valid = 1'b1;
                bus.out_ready = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                end
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.pix_valid = 1'b1;
        #12;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (bus.pix_ready !== 1'b0) begin n_errors++; $display("FAIL reset_pix_ready: got %b expected 0", bus.pix_ready); end
        n_checks++; if (bus.shift_en !== 1'b0) begin n_errors++; $display("FAIL reset_shift_en: got %b expected 0", bus.shift_en); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_pixel !== 8'h00) begin n_errors++; $display("FAIL reset_out_pixel: got %h expected 00", bus.out_pixel); end
        @(negedge clk); #2;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.pix_ready !== 1'b0) begin n_errors++; $display("FAIL idle_pix_ready: got %b expected 0", bus.pix_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_full_rate();
        bit to;
        run_frame(0, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL full_timeout: frame_done not seen in 3000 cycles"); end
        n_checks++; if (f_outs.size() != 16) begin n_errors++; $display("FAIL full_count: got %0d expected 16", f_outs.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= f_outs.size() || f_outs[i] !== EXP[i]) begin
                n_errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, (i < f_outs.size()) ? f_outs[i] : 8'hxx, EXP[i]);
            end
        end
        n_checks++; if (f_acc != 400) begin n_errors++; $display("FAIL full_accepts: got %0d expected 400", f_acc); end
        n_checks++; if (f_last_acc - f_first_acc != 399) begin n_errors++; $display("FAIL full_consecutive: span %0d expected 399", f_last_acc - f_first_acc); end
        n_checks++; if (f_stall != 0) begin n_errors++; $display("FAIL full_stalls: got %0d expected 0", f_stall); end
        n_checks++; if (f_first_ov - f_acc337 != 2) begin n_errors++; $display("FAIL full_first_latency: got %0d expected 2", f_first_ov - f_acc337); end
        n_checks++; if (f_fd_cnt != 1) begin n_errors++; $display("FAIL full_frame_done_count: got %0d expected 1", f_fd_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL full_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        bit to;
        run_frame(1, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL bp_timeout: frame_done not seen in 3000 cycles"); end
        n_checks++; if (f_occ2 !== 1'b1) begin n_errors++; $display("FAIL bp_occ2: got %b expected 1", f_occ2); end
        n_checks++; if (f_stall == 0) begin n_errors++; $display("FAIL bp_stall: got %0d expected >0", f_stall); end
        n_checks++; if (f_outs.size() != 16) begin n_errors++; $display("FAIL bp_count: got %0d expected 16", f_outs.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= f_outs.size() || f_outs[i] !== EXP[i]) begin
                n_errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, (i < f_outs.size()) ? f_outs[i] : 8'hxx, EXP[i]);
            end
        end
        n_checks++; if (f_acc != 400) begin n_errors++; $display("FAIL bp_accepts: got %0d expected 400", f_acc); end
    endtask

    task automatic test_toggle_ready();
        bit to;
        run_frame(2, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL tog_timeout: frame_done not seen in 3000 cycles"); end
        n_checks++; if (f_outs.size() != 16) begin n_errors++; $display("FAIL tog_count: got %0d expected 16", f_outs.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= f_outs.size() || f_outs[i] !== EXP[i]) begin
                n_errors++; $display("FAIL tog_data[%0d]: got %h expected %h", i, (i < f_outs.size()) ? f_outs[i] : 8'hxx, EXP[i]);
            end
        end
        n_checks++; if (f_fd_cnt != 1) begin n_errors++; $display("FAIL tog_frame_done_count: got %0d expected 1", f_fd_cnt); end
    endtask

    task automatic test_start_in_run();
        bit to;
        run_frame(3, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL srun_timeout: frame_done not seen in 3000 cycles"); end
        n_checks++; if (f_acc != 400) begin n_errors++; $display("FAIL srun_accepts: got %0d expected 400", f_acc); end
        n_checks++; if (f_outs.size() != 16) begin n_errors++; $display("FAIL srun_count: got %0d expected 16", f_outs.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= f_outs.size() || f_outs[i] !== EXP[i]) begin
                n_errors++; $display("FAIL srun_data[%0d]: got %h expected %h", i, (i < f_outs.size()) ? f_outs[i] : 8'hxx, EXP[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit to;
        run_frame(5, to);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL ar_pre_out_valid: got %b expected 1", bus.out_valid); end
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ar_busy: got %b expected 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL ar_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (bus.pix_ready !== 1'b0) begin n_errors++; $display("FAIL ar_pix_ready: got %b expected 0", bus.pix_ready); end
        n_checks++; if (bus.shift_en !== 1'b0) begin n_errors++; $display("FAIL ar_shift_en: got %b expected 0", bus.shift_en); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL ar_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_pixel !== 8'h00) begin n_errors++; $display("FAIL ar_out_pixel: got %h expected 00", bus.out_pixel); end
        bus.pix_valid = 1'b0;
        @(negedge clk); #2;
        n_rst = 1'b1;
        run_frame(0, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL ar_timeout: frame_done not seen in 3000 cycles"); end
        n_checks++; if (f_outs.size() != 16) begin n_errors++; $display("FAIL ar_count: got %0d expected 16", f_outs.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= f_outs.size() || f_outs[i] !== EXP[i]) begin
                n_errors++; $display("FAIL ar_data[%0d]: got %h expected %h", i, (i < f_outs.size()) ? f_outs[i] : 8'hxx, EXP[i]);
            end
        end
        n_checks++; if (f_fd_cnt != 1) begin n_errors++; $display("FAIL ar_frame_done_count: got %0d expected 1", f_fd_cnt); end
    endtask

    task automatic test_input_gaps();
        bit to;
        run_frame(4, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL gap_timeout: frame_done not seen in 3000 cycles"); end
        n_checks++; if (f_outs.size() != 16) begin n_errors++; $display("FAIL gap_count: got %0d expected 16", f_outs.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= f_outs.size() || f_outs[i] !== EXP[i]) begin
                n_errors++; $display("FAIL gap_data[%0d]: got %h expected %h", i, (i < f_outs.size()) ? f_outs[i] : 8'hxx, EXP[i]);
            end
        end
        n_checks++; if (f_acc != 400) begin n_errors++; $display("FAIL gap_accepts: got %0d expected 400", f_acc); end
        n_checks++; if (f_fd_cyc <= f_last_out) begin n_errors++; $display("FAIL gap_done_order: frame_done cycle %0d, last output cycle %0d", f_fd_cyc, f_last_out); end
        n_checks++; if (f_fd_cnt != 1) begin n_errors++; $display("FAIL gap_frame_done_count: got %0d expected 1", f_fd_cnt); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_toggle_ready();
        test_start_in_run();
        test_async_reset();
        test_input_gaps();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
